// File: rtl/rvh_l1d_ewrq_mo.sv
// L1D bank eviction/writeback queue: DEPTH victim lines, several SCU Evict/WriteBack in flight, per-entry ack match.
// Evict visible 1 cycle after allocation; data 1 cycle after ack; vld/payload held and selection frozen while rdy=0.
package rvh_l1d_ewrq_pkg;
  localparam int CC_PADDR_W = 56;
  localparam int CC_TID_W   = 8;
  localparam int CC_LINE_W  = 512;
  localparam int CC_SEG_MAX = 16;
  localparam int CC_BANK_W  = 2;

  typedef enum logic [2:0] {
    CC_EVICT       = 3'd0,
    CC_WB_FULL     = 3'd1,
    CC_WB_PARTIAL  = 3'd2,
    CC_READ_SHARED = 3'd3,
    CC_READ_UNIQUE = 3'd4
  } cc_req_type_e;

  typedef enum logic [2:0] {
    CC_RESP_NONE = 3'd0,
    CC_WB_ACK    = 3'd1,
    CC_GRANT     = 3'd2,
    CC_NACK      = 3'd3
  } cc_resp_type_e;

  typedef enum logic [1:0] {
    CC_WB_FULL_DATA    = 2'd0,
    CC_WB_PARTIAL_DATA = 2'd1,
    CC_FILL_DATA       = 2'd2
  } cc_data_type_e;

  typedef struct packed {
    logic [1:0]          cid;
    logic [1:0]          bid;
    logic [CC_TID_W-1:0] pc_tid;
    logic [CC_TID_W-1:0] scu_tid;
    logic [CC_TID_W-1:0] sid;
    logic [1:0]          src_id;
    logic [1:0]          tgt_id;
  } cc_id_t;

  typedef struct packed {
    cc_req_type_e          rtype;
    cc_id_t                id;
    logic [CC_PADDR_W-1:0] addr;
  } cache_scu_cc_req_t;

  typedef struct packed {
    cc_resp_type_e rtype;
    cc_id_t        id;
  } cache_scu_cc_resp_t;

  typedef struct packed {
    cc_data_type_e         rtype;
    cc_id_t                id;
    logic [CC_LINE_W-1:0]  data;
    logic [CC_SEG_MAX-1:0] data_valid;
    logic [CC_SEG_MAX-1:0] data_dirty;
  } cache_scu_cc_data_t;
endpackage

module rvh_l1d_ewrq_mo
  import rvh_l1d_ewrq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int LINE_ADDR_W = 32,
  parameter int SEG_NUM     = 8,
  parameter int SEG_W       = 64,
  parameter int TID_W       = 4,
  parameter int SID_W       = 2,
  parameter int PARTIAL_WB  = 0,
  parameter int BANK_ID     = 0,
  parameter int CORE_ID     = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_vld_i,
  output logic                           new_rdy_o,
  input  logic                           new_wb_i,
  input  logic                           new_inv_i,
  input  logic [LINE_ADDR_W-1:0]         new_addr_i,
  input  logic [SEG_NUM*SEG_W-1:0]       new_dat_i,
  input  logic [SEG_NUM-1:0]             new_dirty_i,
  input  logic [LINE_ADDR_W-1:0]         lkup_addr_i,
  output logic                           lkup_hit_o,
  output logic [DEPTH*LINE_ADDR_W-1:0]   ewrq_addr_o,
  output logic [DEPTH-1:0]               ewrq_vld_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           pc_scu_evict_vld_o,
  output cache_scu_cc_req_t              pc_scu_evict_o,
  input  logic                           pc_scu_evict_rdy_i,
  input  logic                           scu_pc_resp_vld_i,
  input  cache_scu_cc_resp_t             scu_pc_resp_i,
  output logic                           scu_pc_resp_rdy_o,
  output logic                           pc_scu_data_vld_o,
  output cache_scu_cc_data_t             pc_scu_data_o,
  input  logic                           pc_scu_data_rdy_i,
  output logic                           err_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int LINE_W = SEG_NUM * SEG_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {E_FREE, E_PEND, E_SENT, E_ACKED} ent_st_e;

  ent_st_e                      st_q [DEPTH];
  ent_st_e                      st_d [DEPTH];
  logic [LINE_ADDR_W-1:0]       addr_q [DEPTH];
  logic [LINE_W-1:0]            dat_q [DEPTH];
  logic [SEG_NUM-1:0]           mask_q [DEPTH];
  logic [TID_W-1:0]             scu_tid_q [DEPTH];
  logic [SID_W-1:0]             sid_q [DEPTH];
  logic [DEPTH-1:0]             has_data_q;
  // age_q[i][j] = 1 when entry i was allocated before entry j
  logic [DEPTH-1:0][DEPTH-1:0]  age_q;

  logic [DEPTH-1:0] free_v, pend_v, acked_v, busy_v, dup_v, lkup_v;
  logic [IDX_W-1:0] alloc_idx, ev_idx, dt_idx, ev_idx_q, dt_idx_q, ack_idx;
  logic             ev_hold_q, dt_hold_q, err_q;
  logic             alloc_en, has_data_new, ev_hs, dt_hs, ack_vld, ack_ok, ack_err;

  function automatic logic [IDX_W-1:0] pick_oldest(input logic [DEPTH-1:0] cand,
                                                   input logic [DEPTH-1:0][DEPTH-1:0] age);
    logic [IDX_W-1:0] sel;
    logic             oldest;
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && cand[j] && !age[i][j]) oldest = 1'b0;
      end
      if (oldest) sel = IDX_W'(i);
    end
    return sel;
  endfunction

  always_comb begin
    free_v  = '0;
    pend_v  = '0;
    acked_v = '0;
    busy_v  = '0;
    dup_v   = '0;
    lkup_v  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_v[i]  = (st_q[i] == E_FREE);
      pend_v[i]  = (st_q[i] == E_PEND);
      acked_v[i] = (st_q[i] == E_ACKED);
      busy_v[i]  = (st_q[i] != E_FREE);
      dup_v[i]   = busy_v[i] && (addr_q[i] == new_addr_i);
      lkup_v[i]  = busy_v[i] && (addr_q[i] == lkup_addr_i);
    end
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_v[i]) alloc_idx = IDX_W'(i);
    end
  end

  // Duplicate in-flight lines are refused so an address never has two entries
  assign new_rdy_o    = (|free_v) && !(|dup_v);
  assign alloc_en     = new_vld_i && new_rdy_o && !new_inv_i;
  assign has_data_new = new_wb_i && !((PARTIAL_WB != 0) && (new_dirty_i == '0));
  assign lkup_hit_o   = |lkup_v;
  assign ewrq_vld_o   = busy_v;
  assign scu_pc_resp_rdy_o = 1'b1;
  assign err_o        = err_q;

  assign ev_idx             = ev_hold_q ? ev_idx_q : pick_oldest(pend_v, age_q);
  assign pc_scu_evict_vld_o = ev_hold_q || (|pend_v);
  assign ev_hs              = pc_scu_evict_vld_o && pc_scu_evict_rdy_i;

  // A newly acked older entry must not steal a beat already on the bus
  assign dt_idx            = dt_hold_q ? dt_idx_q : pick_oldest(acked_v, age_q);
  assign pc_scu_data_vld_o = dt_hold_q || (|acked_v);
  assign dt_hs             = pc_scu_data_vld_o && pc_scu_data_rdy_i;

  assign ack_vld = scu_pc_resp_vld_i && (scu_pc_resp_i.rtype == CC_WB_ACK);
  assign ack_idx = scu_pc_resp_i.id.pc_tid[IDX_W-1:0];
  assign ack_ok  = ack_vld && (scu_pc_resp_i.id.pc_tid < CC_TID_W'(DEPTH)) &&
                   (st_q[ack_idx] == E_SENT);
  assign ack_err = ack_vld && !ack_ok;

  always_comb begin
    count_o     = '0;
    ewrq_addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_o = count_o + CNT_W'(busy_v[i]);
      ewrq_addr_o[i*LINE_ADDR_W +: LINE_ADDR_W] = addr_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i] = st_q[i];
      if (alloc_en && alloc_idx == IDX_W'(i)) st_d[i] = E_PEND;
      if (ev_hs && ev_idx == IDX_W'(i))       st_d[i] = E_SENT;
      if (ack_ok && ack_idx == IDX_W'(i))     st_d[i] = has_data_q[i] ? E_ACKED : E_FREE;
      if (dt_hs && dt_idx == IDX_W'(i))       st_d[i] = E_FREE;
    end
  end

  always_comb begin
    pc_scu_evict_o           = '0;
    pc_scu_evict_o.rtype     = has_data_q[ev_idx] ?
                               ((PARTIAL_WB != 0) ? CC_WB_PARTIAL : CC_WB_FULL) : CC_EVICT;
    pc_scu_evict_o.id.cid    = 2'(CORE_ID);
    pc_scu_evict_o.id.bid    = 2'(BANK_ID);
    pc_scu_evict_o.id.pc_tid = CC_TID_W'(ev_idx);
    pc_scu_evict_o.addr      = CC_PADDR_W'({addr_q[ev_idx], CC_BANK_W'(BANK_ID), {OFF_W{1'b0}}});
  end

  always_comb begin
    pc_scu_data_o            = '0;
    pc_scu_data_o.rtype      = (PARTIAL_WB != 0) ? CC_WB_PARTIAL_DATA : CC_WB_FULL_DATA;
    pc_scu_data_o.id.cid     = 2'(CORE_ID);
    pc_scu_data_o.id.bid     = 2'(BANK_ID);
    pc_scu_data_o.id.pc_tid  = CC_TID_W'(dt_idx);
    pc_scu_data_o.id.scu_tid = CC_TID_W'(scu_tid_q[dt_idx]);
    pc_scu_data_o.id.sid     = CC_TID_W'(sid_q[dt_idx]);
    pc_scu_data_o.data       = CC_LINE_W'(dat_q[dt_idx]);
    pc_scu_data_o.data_valid = (PARTIAL_WB != 0) ? CC_SEG_MAX'(mask_q[dt_idx]) :
                                                   CC_SEG_MAX'({SEG_NUM{1'b1}});
    pc_scu_data_o.data_dirty = pc_scu_data_o.data_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]      <= E_FREE;
        addr_q[i]    <= '0;
        dat_q[i]     <= '0;
        mask_q[i]    <= '0;
        scu_tid_q[i] <= '0;
        sid_q[i]     <= '0;
      end
      has_data_q <= '0;
      age_q      <= '0;
      ev_hold_q  <= 1'b0;
      ev_idx_q   <= '0;
      dt_hold_q  <= 1'b0;
      dt_idx_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= st_d[i];
      if (alloc_en) begin
        addr_q[alloc_idx]     <= new_addr_i;
        dat_q[alloc_idx]      <= new_dat_i;
        mask_q[alloc_idx]     <= new_dirty_i;
        has_data_q[alloc_idx] <= has_data_new;
        for (int j = 0; j < DEPTH; j++) begin
          age_q[alloc_idx][j] <= 1'b0;
          age_q[j][alloc_idx] <= (j != int'(alloc_idx));
        end
      end
      if (ack_ok) begin
        scu_tid_q[ack_idx] <= scu_pc_resp_i.id.scu_tid[TID_W-1:0];
        sid_q[ack_idx]     <= scu_pc_resp_i.id.sid[SID_W-1:0];
      end
      ev_hold_q <= pc_scu_evict_vld_o && !pc_scu_evict_rdy_i;
      ev_idx_q  <= ev_idx;
      dt_hold_q <= pc_scu_data_vld_o && !pc_scu_data_rdy_i;
      dt_idx_q  <= dt_idx;
      err_q     <= err_q | ack_err;
    end
  end

endmodule
